lsu_mem_ctrl: RTL and testbench

- Load/store control stage sitting directly upstream of the byte-addressed data RAM.
- Accepts one memory request at a time from the MEM pipeline stage over a valid/ready handshake.
- Drives the RAM address, data, enables and width code, then returns load data or a fault record over a response handshake.
- Converts RAM access-fault flags and, optionally, misalignment into RISC-V exception causes.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align_check.sv | 12 +
 rtl/lsu_mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store control stage
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   // Width code: bit2 = unsigned, bit1 = word, bit0 = half
   localparam logic [2:0] W_BYTE         = 3'b000;
   localparam logic [2:0] W_HALF         = 3'b001;
   localparam logic [2:0] W_WORD         = 3'b010;
   localparam int         W_UNSIGNED_BIT = 2;

   localparam int CAUSE_LOAD_MISALIGNED  = 4;
   localparam int CAUSE_LOAD_ACCESS      = 5;
   localparam int CAUSE_STORE_MISALIGNED = 6;
   localparam int CAUSE_STORE_ACCESS     = 7;

   function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] width);
      if (width[1])
         return |addr_lo;
      if (width[0])
         return addr_lo[0];
      return 1'b0;
   endfunction

endpackage

// File: rtl/lsu_align_check.sv
// rtl/lsu_align_check.sv - combinational misalignment detector for half/word accesses
module lsu_align_check
   import lsu_pkg::*;
(
   input  logic [1:0] i_addr_lo,
   input  logic [2:0] i_width,
   output logic       o_misaligned
);

   assign o_misaligned = is_misaligned(i_addr_lo, i_width);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store control stage in front of the data RAM
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int CAUSE_W = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [XLEN-1:0]    req_addr,
   input  logic [XLEN-1:0]    req_wdata,
   input  logic [2:0]         req_width,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [XLEN-1:0]    resp_rdata,
   output logic               resp_fault,
   output logic [CAUSE_W-1:0] resp_cause,
   output logic [XLEN-1:0]    resp_tval,
   output logic [XLEN-1:0]    mem_addr,
   output logic [XLEN-1:0]    mem_wdata,
   output logic               mem_we,
   output logic               mem_re,
   output logic [2:0]         mem_width,
   input  logic [XLEN-1:0]    mem_rdata,
   input  logic               mem_l_fault,
   input  logic               mem_s_fault
);

   lsu_state_e          r_state;
   lsu_state_e          w_next_state;
   logic                w_misaligned;

   logic                r_we;
   logic [XLEN-1:0]     r_addr;
   logic [XLEN-1:0]     r_wdata;
   logic [2:0]          r_width;

   logic [XLEN-1:0]     r_rdata;
   logic                r_fault;
   logic [CAUSE_W-1:0]  r_cause;
   logic [XLEN-1:0]     r_tval;

`ifdef LSU_MISALIGN_TRAP_EN
   lsu_align_check u_align_check (
      .i_addr_lo    (req_addr[1:0]),
      .i_width      (req_width),
      .o_misaligned (w_misaligned)
   );
`else
   assign w_misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (req_valid)
               w_next_state = w_misaligned ? RESP : ACCESS;
         end
         ACCESS:  w_next_state = RESP;
         RESP: begin
            if (resp_ready)
               w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // RAM strobes decode from state so a stalled RESP can never repeat a store
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_width  = W_BYTE;
      case (r_state)
         IDLE:   req_ready = 1'b1;
         ACCESS: begin
            mem_we    = r_we;
            mem_re    = ~r_we;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
            mem_width = r_width;
         end
         RESP:   resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_width <= W_BYTE;
         r_rdata <= '0;
         r_fault <= 1'b0;
         r_cause <= '0;
         r_tval  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_width <= req_width;
                  if (w_misaligned) begin
                     r_rdata <= '0;
                     r_fault <= 1'b1;
                     r_cause <= req_we ? CAUSE_W'(CAUSE_STORE_MISALIGNED)
                                       : CAUSE_W'(CAUSE_LOAD_MISALIGNED);
                     r_tval  <= req_addr;
                  end
               end
            end
            ACCESS: begin
               r_rdata <= '0;
               r_fault <= 1'b0;
               r_cause <= '0;
               r_tval  <= '0;
               if (!r_we && mem_l_fault) begin
                  r_fault <= 1'b1;
                  r_cause <= CAUSE_W'(CAUSE_LOAD_ACCESS);
                  r_tval  <= r_addr;
               end else if (r_we && mem_s_fault) begin
                  r_fault <= 1'b1;
                  r_cause <= CAUSE_W'(CAUSE_STORE_ACCESS);
                  r_tval  <= r_addr;
               end else if (!r_we) begin
                  r_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_fault = r_fault;
   assign resp_cause = r_cause;
   assign resp_tval  = r_tval;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl with a byte RAM model
module tb_lsu_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_width;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [3:0]  resp_cause;
   logic [31:0] resp_tval;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [2:0]  mem_width;
   logic [31:0] mem_rdata;
   logic        mem_l_fault;
   logic        mem_s_fault;

   int checks = 0;
   int fails  = 0;
   int wr_count = 0;
   int re_count = 0;

   logic [7:0] ram [0:1023];
   logic       w_fault_region;
   logic [9:0] a0, a1, a2, a3;

   lsu_mem_ctrl #(.XLEN(32), .CAUSE_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault), .resp_cause(resp_cause), .resp_tval(resp_tval),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_width(mem_width), .mem_rdata(mem_rdata),
      .mem_l_fault(mem_l_fault), .mem_s_fault(mem_s_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: 0x200-0x2FF is a fault region; reads extend per width code
   assign w_fault_region = (mem_addr[31:8] == 24'h2);
   assign mem_l_fault = mem_re & w_fault_region;
   assign mem_s_fault = mem_we & w_fault_region;

   always_comb begin
      a0 = mem_addr[9:0];
      a1 = a0 + 10'd1;
      a2 = a0 + 10'd2;
      a3 = a0 + 10'd3;
      mem_rdata = 32'h0;
      if (mem_re && !w_fault_region) begin
         case (mem_width[1:0])
            2'b00: mem_rdata = mem_width[2] ? {24'h0, ram[a0]} : {{24{ram[a0][7]}}, ram[a0]};
            2'b01: mem_rdata = mem_width[2] ? {16'h0, ram[a1], ram[a0]}
                                            : {{16{ram[a1][7]}}, ram[a1], ram[a0]};
            default: mem_rdata = {ram[a3], ram[a2], ram[a1], ram[a0]};
         endcase
      end
   end

   always @(negedge clk) begin
      if (mem_re) re_count = re_count + 1;
      if (mem_we) begin
         wr_count = wr_count + 1;
         if (!w_fault_region) begin
            ram[mem_addr[9:0]] = mem_wdata[7:0];
            if (mem_width[1] | mem_width[0]) ram[mem_addr[9:0] + 10'd1] = mem_wdata[15:8];
            if (mem_width[1]) begin
               ram[mem_addr[9:0] + 10'd2] = mem_wdata[23:16];
               ram[mem_addr[9:0] + 10'd3] = mem_wdata[31:24];
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] width);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_width = width;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic release_resp();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
      checks++; if ({mem_we, mem_re} !== 2'b00) begin fails++; $display("FAIL rst_mem_en: got %b want 00", {mem_we, mem_re}); end
      checks++; if ({mem_addr, mem_wdata, mem_width} !== 67'h0) begin fails++; $display("FAIL rst_mem_bus: got %h/%h/%h want 0", mem_addr, mem_wdata, mem_width); end
      checks++; if ({resp_rdata, resp_fault, resp_cause, resp_tval} !== 69'h0) begin fails++; $display("FAIL rst_resp_regs: got %h %b %h %h want 0", resp_rdata, resp_fault, resp_cause, resp_tval); end
   endtask

   task automatic test_store_load_word();
      int wr0;
      wr0 = wr_count;
      issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
      checks++; if ({mem_we, mem_re} !== 2'b10) begin fails++; $display("FAIL sw_access_en: got %b want 10", {mem_we, mem_re}); end
      checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_bus: got %h/%h want 10/deadbeef", mem_addr, mem_wdata); end
      checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL sw_early_valid: got %b want 0", resp_valid); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL sw_resp: got v%b f%b we%b want v1 f0 we0", resp_valid, resp_fault, mem_we); end
      release_resp();
      checks++; if (wr_count - wr0 !== 1) begin fails++; $display("FAIL sw_write_count: got %0d want 1", wr_count - wr0); end
      checks++; if ({ram[19], ram[18], ram[17], ram[16]} !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_ram: got %h want deadbeef", {ram[19], ram[18], ram[17], ram[16]}); end
      checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL sw_back_idle: got %b want 1", req_ready); end
      issue(1'b0, 32'h10, 32'h0, 3'b010);
      checks++; if ({mem_we, mem_re} !== 2'b01) begin fails++; $display("FAIL lw_access_en: got %b want 01", {mem_we, mem_re}); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_fault !== 1'b0) begin fails++; $display("FAIL lw_resp: got v%b %h f%b want v1 deadbeef f0", resp_valid, resp_rdata, resp_fault); end
      release_resp();
   endtask

   task automatic test_byte_ext();
      issue(1'b1, 32'h10, 32'h00000080, 3'b000);
      @(posedge clk); #1;
      release_resp();
      checks++; if ({ram[17], ram[16]} !== 16'hBE80) begin fails++; $display("FAIL sb_ram: got %h want be80", {ram[17], ram[16]}); end
      issue(1'b0, 32'h10, 32'h0, 3'b000);
      @(posedge clk); #1;
      checks++; if (resp_rdata !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_signed: got %h want ffffff80", resp_rdata); end
      release_resp();
      issue(1'b0, 32'h10, 32'h0, 3'b100);
      @(posedge clk); #1;
      checks++; if (resp_rdata !== 32'h00000080) begin fails++; $display("FAIL lbu_unsigned: got %h want 00000080", resp_rdata); end
      release_resp();
   endtask

   task automatic test_access_fault();
      issue(1'b0, 32'h200, 32'h0, 3'b010);
      @(posedge clk); #1;
      checks++; if ({resp_fault, resp_cause} !== 5'h15 || resp_tval !== 32'h200 || resp_rdata !== 32'h0) begin fails++; $display("FAIL lw_fault: got f%b c%0d t%h d%h want f1 c5 t200 d0", resp_fault, resp_cause, resp_tval, resp_rdata); end
      release_resp();
      issue(1'b1, 32'h200, 32'h55, 3'b010);
      @(posedge clk); #1;
      checks++; if ({resp_fault, resp_cause} !== 5'h17 || resp_tval !== 32'h200) begin fails++; $display("FAIL sw_fault: got f%b c%0d t%h want f1 c7 t200", resp_fault, resp_cause, resp_tval); end
      release_resp();
      issue(1'b0, 32'h10, 32'h0, 3'b010);
      @(posedge clk); #1;
      checks++; if ({resp_fault, resp_cause, resp_tval} !== 37'h0) begin fails++; $display("FAIL fault_cleared: got f%b c%0d t%h want 0", resp_fault, resp_cause, resp_tval); end
      release_resp();
   endtask

   task automatic test_stall();
      int wr0;
      int bad;
      wr0 = wr_count;
      bad = 0;
      issue(1'b1, 32'h20, 32'h12345678, 3'b010);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hA5A5A5A5; req_width = 3'b010;
         req_valid = (i % 2 == 0);
         @(posedge clk); #1;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || mem_we !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'h0)
            bad++;
      end
      req_valid = 1'b0;
      checks++; if (bad !== 0) begin fails++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
      checks++; if (wr_count - wr0 !== 1) begin fails++; $display("FAIL stall_single_write: got %0d want 1", wr_count - wr0); end
      release_resp();
      checks++; if ({ram[67], ram[66], ram[65], ram[64]} !== 32'h0) begin fails++; $display("FAIL stall_ignored_req: got %h want 0", {ram[67], ram[66], ram[65], ram[64]}); end
      checks++; if ({ram[35], ram[34], ram[33], ram[32]} !== 32'h12345678) begin fails++; $display("FAIL stall_store_data: got %h want 12345678", {ram[35], ram[34], ram[33], ram[32]}); end
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL stall_exit: got r%b v%b want r1 v0", req_ready, resp_valid); end
   endtask

   task automatic test_misalign();
      int re0;
      re0 = re_count;
      issue(1'b0, 32'h11, 32'h0, 3'b001);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++; if (resp_valid !== 1'b1 || {resp_fault, resp_cause} !== 5'h14 || resp_tval !== 32'h11 || resp_rdata !== 32'h0) begin fails++; $display("FAIL lh_misalign: got v%b f%b c%0d t%h d%h want v1 f1 c4 t11 d0", resp_valid, resp_fault, resp_cause, resp_tval, resp_rdata); end
      release_resp();
      checks++; if (re_count - re0 !== 0) begin fails++; $display("FAIL lh_misalign_no_read: got %0d want 0", re_count - re0); end
      issue(1'b1, 32'h12, 32'h99, 3'b010);
      checks++; if (resp_valid !== 1'b1 || {resp_fault, resp_cause} !== 5'h16 || resp_tval !== 32'h12 || mem_we !== 1'b0) begin fails++; $display("FAIL sw_misalign: got v%b f%b c%0d t%h we%b want v1 f1 c6 t12 we0", resp_valid, resp_fault, resp_cause, resp_tval, mem_we); end
      release_resp();
`else
      checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h11 || mem_width !== 3'b001) begin fails++; $display("FAIL lh_pass_bus: got re%b %h w%b want re1 11 w001", mem_re, mem_addr, mem_width); end
      @(posedge clk); #1;
      checks++; if (resp_fault !== 1'b0 || resp_rdata !== 32'hFFFFADBE) begin fails++; $display("FAIL lh_pass_resp: got f%b %h want f0 ffffadbe", resp_fault, resp_rdata); end
      release_resp();
      checks++; if (re_count - re0 !== 1) begin fails++; $display("FAIL lh_pass_read: got %0d want 1", re_count - re0); end
`endif
   endtask

   task automatic test_reset_mid_access();
      int wr0;
      wr0 = wr_count;
      issue(1'b1, 32'h30, 32'hCAFEF00D, 3'b010);
      rst_n = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_async_we: got %b want 0", mem_we); end
      @(negedge clk); #1;
      checks++; if ({ram[51], ram[50], ram[49], ram[48]} !== 32'h0 || wr_count - wr0 !== 0) begin fails++; $display("FAIL rst_no_write: got %h n%0d want 0 n0", {ram[51], ram[50], ram[49], ram[48]}, wr_count - wr0); end
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL rst_release: got r%b v%b want r1 v0", req_ready, resp_valid); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_width = 3'b000; resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_store_load_word();
      test_byte_ext();
      test_access_fault();
      test_stall();
      test_misalign();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
